// File: rtl/proj_scheduler_if.sv
// Bundle of the requester, projection-unit and result handshake signals of
// proj_scheduler. The slave view belongs to the scheduler; the master view
// belongs to whatever drives the requests and plays the projection unit.
interface proj_scheduler_if;
  // Requesters
  logic        REQ0, REQ1;
  logic [31:0] X0, Y0, Z0;
  logic [31:0] X1, Y1, Z1;
  logic        GNT0, GNT1;
  // Shared projection unit
  logic        PROJ_START;
  logic [31:0] PROJ_X, PROJ_Y, PROJ_Z;
  logic        PROJ_DONE;
  logic [31:0] PROJ_NEWX, PROJ_NEWY, PROJ_NEWZ;
  // Screen-space result
  logic        OUT_VALID, OUT_READY;
  logic [15:0] SCR_X, SCR_Y;
  logic [31:0] SCR_Z;
  logic        OUT_ID;
  // Status
  logic        BUSY, ERR;

  modport slave (
    input  REQ0, REQ1, X0, Y0, Z0, X1, Y1, Z1,
    output GNT0, GNT1,
    output PROJ_START, PROJ_X, PROJ_Y, PROJ_Z,
    input  PROJ_DONE, PROJ_NEWX, PROJ_NEWY, PROJ_NEWZ,
    output OUT_VALID, SCR_X, SCR_Y, SCR_Z, OUT_ID,
    input  OUT_READY,
    output BUSY, ERR
  );

  modport master (
    output REQ0, REQ1, X0, Y0, Z0, X1, Y1, Z1,
    input  GNT0, GNT1,
    input  PROJ_START, PROJ_X, PROJ_Y, PROJ_Z,
    output PROJ_DONE, PROJ_NEWX, PROJ_NEWY, PROJ_NEWZ,
    input  OUT_VALID, SCR_X, SCR_Y, SCR_Z, OUT_ID,
    output OUT_READY,
    input  BUSY, ERR
  );
endinterface

// File: rtl/proj_scheduler.sv
// Two-requester scheduler for one shared vertex projection unit.
// A round-robin grant captures the winning vertex, the projection unit is
// started and awaited (with a timeout), and the normalised result is mapped
// to clamped integer pixel coordinates held until the consumer accepts it.
module proj_scheduler #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TIMEOUT  = 1023
) (
  input  logic             CLK,
  input  logic             RESET_N,
  proj_scheduler_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VP    = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic signed [65:0] EXT_X = 66'(SCREEN_W);
  localparam logic signed [65:0] EXT_Y = 66'(SCREEN_H);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_prio;     // 1: requester 1 wins a tie
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_px, r_py, r_pz;
  logic [31:0]      r_nx, r_ny, r_nz;
  logic [15:0]      r_scr_x, r_scr_y;
  logic [31:0]      r_scr_z;
  logic             r_out_id;

  logic             w_idle;
  logic             w_gnt0, w_gnt1;
  logic             w_timeout;

  // NDC (Q16.15, nominally [-1,+1]) to pixel: floor((ndc + 1.0) * extent / 2),
  // clamped to [0, extent-1]. The /2 and the Q15 scaling fold into one >>> 16.
  function automatic logic [15:0] vp_map(input logic [31:0] ndc,
                                         input logic signed [65:0] extent);
    logic signed [32:0] sum;
    logic signed [65:0] pix;
    sum = $signed({ndc[31], ndc}) + 33'sh0_8000;
    pix = (66'(sum) * extent) >>> 16;
    if (pix < 66'sd0)
      return 16'd0;
    else if (pix >= extent)
      return 16'(extent - 66'sd1);
    else
      return pix[15:0];
  endfunction

  // Grants exist only in IDLE and are suppressed while reset is held.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt0 = RESET_N && w_idle && bus.REQ0 && (!bus.REQ1 || !r_prio);
  assign w_gnt1 = RESET_N && w_idle && bus.REQ1 && (!bus.REQ0 ||  r_prio);

  // Last permitted WAIT cycle without a result: abort the job.
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_LAST) && !bus.PROJ_DONE;

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.PROJ_DONE)  w_next = S_VP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_VP:    w_next = S_HOLD;
      S_HOLD:  if (bus.OUT_READY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Grant bookkeeping: operand capture, owner and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_px    <= '0;
      r_py    <= '0;
      r_pz    <= '0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else if (w_gnt0) begin
      r_px    <= bus.X0;
      r_py    <= bus.Y0;
      r_pz    <= bus.Z0;
      r_owner <= 1'b0;
      r_prio  <= 1'b1;
    end else if (w_gnt1) begin
      r_px    <= bus.X1;
      r_py    <= bus.Y1;
      r_pz    <= bus.Z1;
      r_owner <= 1'b1;
      r_prio  <= 1'b0;
    end
  end

  // WAIT cycle counter, cleared while issuing so it starts at 0 in WAIT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                r_cnt <= '0;
    else if (r_state == S_ISSUE) r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + 1'b1;
  end

  // Projection result capture; DONE is ignored outside WAIT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_nx <= '0;
      r_ny <= '0;
      r_nz <= '0;
    end else if (r_state == S_WAIT && bus.PROJ_DONE) begin
      r_nx <= bus.PROJ_NEWX;
      r_ny <= bus.PROJ_NEWY;
      r_nz <= bus.PROJ_NEWZ;
    end
  end

  // Viewport stage: registers the screen result, which then holds through HOLD.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scr_x  <= '0;
      r_scr_y  <= '0;
      r_scr_z  <= '0;
      r_out_id <= 1'b0;
    end else if (r_state == S_VP) begin
      r_scr_x  <= vp_map(r_nx, EXT_X);
      r_scr_y  <= vp_map(r_ny, EXT_Y);
      r_scr_z  <= r_nz;
      r_out_id <= r_owner;
    end
  end

  assign bus.GNT0       = w_gnt0;
  assign bus.GNT1       = w_gnt1;
  assign bus.PROJ_START = (r_state == S_ISSUE);
  assign bus.PROJ_X     = r_px;
  assign bus.PROJ_Y     = r_py;
  assign bus.PROJ_Z     = r_pz;
  assign bus.OUT_VALID  = (r_state == S_HOLD);
  assign bus.SCR_X      = r_scr_x;
  assign bus.SCR_Y      = r_scr_y;
  assign bus.SCR_Z      = r_scr_z;
  assign bus.OUT_ID     = r_out_id;
  assign bus.BUSY       = !w_idle;
  assign bus.ERR        = w_timeout;

endmodule
